// File: rtl/octaver_pkg.sv
// octaver_pkg: mode codes, FSM states and accumulator guard width for octaver_mix
package octaver_pkg;
  localparam logic [1:0] MODE_BYP  = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  localparam int ACC_GUARD = 2;
  typedef enum logic [2:0] {IDLE, RD_DN, RD_UP, MIX, OUT} state_t;
endpackage

// File: rtl/octaver_mix_if.sv
// octaver_mix_if: codec-side sample bus and effects-side output bus of the octaver
interface octaver_mix_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 13);
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] y;
  logic audio_ready;
  logic [1:0] mode;
  logic [ADDR_WIDTH-1:0] win_len;
  logic overrun_clr;
  logic y_valid;
  logic indicator;
  logic overrun;
  modport master(output x, audio_ready, mode, win_len, overrun_clr,
                 input y, y_valid, indicator, overrun);
  modport slave(input x, audio_ready, mode, win_len, overrun_clr,
                output y, y_valid, indicator, overrun);
endinterface

// File: rtl/octaver_ram.sv
// octaver_ram: 1-write/1-read synchronous window buffer, read-first on address collision
module octaver_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH = 4000
) (
  input  logic CLK,
  input  logic we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge CLK) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/octaver_mix.sv
// octaver_mix: dry sample mixed with half-rate and/or double-rate reads of a circular window
module octaver_mix import octaver_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH = 4000
) (
  input logic CLK,
  input logic rst,
  octaver_mix_if.slave bus
);
  localparam int ACC_W = DATA_WIDTH + ACC_GUARD;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'($signed({1'b0, {(DATA_WIDTH-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'($signed({1'b1, {(DATA_WIDTH-1){1'b0}}}));
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] wp, wp_s, len_s, len_in, addr_up, ra;
  logic [ADDR_WIDTH:0] dbl, up_full;
  logic [1:0] mode_s;
  logic primed, primed_s, accept, wrap;
  logic [DATA_WIDTH-1:0] rd, y_sat;
  logic signed [DATA_WIDTH-1:0] x_s, dn, up;
  logic signed [ACC_W-1:0] dx, ux, half, wet, acc;
  assign accept = state == IDLE && bus.audio_ready;
  assign len_in = (bus.win_len == '0 || 32'(bus.win_len) > DEPTH) ? ADDR_WIDTH'(DEPTH) : bus.win_len;
  // >= rather than == so a window shrunk below wp wraps on the next sample
  assign wrap = ({1'b0, wp} + (ADDR_WIDTH+1)'(1)) >= {1'b0, len_in};
  assign dbl = {wp_s, 1'b0};
  assign up_full = dbl < {1'b0, len_s} ? dbl : dbl - {1'b0, len_s};
  assign addr_up = ADDR_WIDTH'(up_full);
  assign ra = state == IDLE ? wp >> 1 : addr_up;
  assign dx = ACC_W'(dn);
  assign ux = ACC_W'(up);
  assign half = (dx + ux) >>> 1;
  assign wet = !primed_s ? '0 : mode_s == MODE_DN ? dx : mode_s == MODE_UP ? ux : mode_s == MODE_BOTH ? half : '0;
  assign y_sat = acc > HI ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : acc < LO ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : acc[DATA_WIDTH-1:0];
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (bus.audio_ready ? RD_DN : IDLE) : state == OUT ? IDLE : state_t'(state + 3'd1);
  end
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      primed <= 1'b0;
      bus.indicator <= 1'b0;
      bus.overrun <= 1'b0;
      bus.y <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      state <= nxt;
      bus.y_valid <= state == OUT;
      if (state == OUT) bus.y <= y_sat;
      bus.overrun <= (bus.audio_ready && state != IDLE) ? 1'b1 : bus.overrun_clr ? 1'b0 : bus.overrun;
      if (accept) begin
        wp <= wrap ? '0 : wp + ADDR_WIDTH'(1);
        if (wrap) bus.indicator <= ~bus.indicator;
        if (wrap) primed <= 1'b1;
      end
    end
  end
  // Datapath registers hold per-sample context; primed_s is the pre-wrap value so the wrapping sample stays dry
  always_ff @(posedge CLK) begin
    if (accept) begin
      x_s <= bus.x;
      mode_s <= bus.mode;
      len_s <= len_in;
      wp_s <= wp;
      primed_s <= primed;
    end
    if (state == RD_DN) dn <= rd;
    if (state == RD_UP) up <= rd;
    if (state == MIX) acc <= ACC_W'(x_s) + wet;
  end
  octaver_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ram (
    .CLK(CLK),
    .we(accept),
    .wa(wp),
    .wd(bus.x),
    .ra(ra),
    .rd(rd)
  );
endmodule

// File: tb/tb_octaver_mix.sv
// tb_octaver_mix: randomized scoreboard bench against a sample-level behavioural model
module tb_octaver_mix;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int DEPTH = 4000;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;
  octaver_mix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  octaver_mix #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (.CLK(CLK), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int mem[DEPTH];
  int wp = 0;
  bit primed = 1'b0;
  bit ind = 1'b0;
  task automatic chk(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  function automatic int rnd();
    logic [DW-1:0] r;
    r = DW'($urandom);
    return int'($signed(r));
  endfunction
  function automatic int sat(int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  // One accepted sample: buffer read-before-write for dn, after-write for up, then pointer rules
  function automatic int model(int xv, int md, int wl);
    int L, dn, up, u, wet;
    L = (wl == 0 || wl > DEPTH) ? DEPTH : wl;
    dn = mem[wp / 2];
    mem[wp] = xv;
    u = (2 * wp < L) ? 2 * wp : 2 * wp - L;
    up = mem[u];
    wet = !primed ? 0 : md == 1 ? dn : md == 2 ? up : md == 3 ? (dn + up) >>> 1 : 0;
    if (wp >= L - 1) begin
      wp = 0;
      ind = !ind;
      primed = 1'b1;
    end else wp++;
    return sat(xv + wet);
  endfunction
  always @(negedge CLK) begin
    if (bus.y_valid) begin
      if (exp_q.size() == 0) chk("unexpected y_valid", 1, 0);
      else chk("y", int'($signed(bus.y)), exp_q.pop_front());
    end
  end
  task automatic send(int xv, int md, int wl, int gap = 0);
    @(negedge CLK);
    bus.x = DW'(xv);
    bus.mode = 2'(md);
    bus.win_len = AW'(wl);
    bus.audio_ready = 1'b1;
    exp_q.push_back(model(xv, md, wl));
    @(negedge CLK);
    bus.audio_ready = 1'b0;
    repeat (3 + gap) @(negedge CLK);
  endtask
  initial begin
    bus.x = '0;
    bus.mode = 2'b00;
    bus.win_len = '0;
    bus.audio_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset y", int'(bus.y), 0);
    chk("reset y_valid", int'(bus.y_valid), 0);
    chk("reset indicator", int'(bus.indicator), 0);
    chk("reset overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    for (int n = 1; n <= 8000; n++) begin
      send(rnd(), int'($urandom_range(0, 3)), 0);
      if (n == 3999 || n == 4000 || n == 7999 || n == 8000) chk($sformatf("indicator@%0d", n), int'(bus.indicator), int'(ind));
    end
    for (int n = 0; n < 10; n++) send(rnd(), int'($urandom_range(0, 3)), 0);
    send(rnd(), 3, 5);
    chk("shrink wrap indicator", int'(bus.indicator), int'(ind));
    send(rnd(), 1, 5);
    // abort a sample in RD_UP; its RAM write has already happened
    @(negedge CLK);
    bus.x = DW'(1234);
    bus.mode = 2'b11;
    bus.win_len = '0;
    bus.audio_ready = 1'b1;
    void'(model(1234, 3, 0));
    @(negedge CLK);
    bus.audio_ready = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk("mid reset y", int'(bus.y), 0);
    chk("mid reset y_valid", int'(bus.y_valid), 0);
    chk("mid reset indicator", int'(bus.indicator), 0);
    rst = 1'b0;
    wp = 0;
    primed = 1'b0;
    ind = 1'b0;
    repeat (6) @(negedge CLK);
    for (int k = 1; k <= 8; k++) send(k, 1, 8);
    for (int k = 0; k < 8; k++) send(100 + k, 1, 8);
    for (int k = 1; k <= 8; k++) send(k, 2, 8);
    for (int k = 0; k < 8; k++) send(100 + k, 2, 8);
    send(28672, 1, 2);
    send(28672, 1, 2);
    send(-28672, 1, 2);
    send(-28672, 1, 2);
    for (int n = 0; n < 300; n++)
      send(rnd(), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 8191)) : int'($urandom_range(0, 16)),
           int'($urandom_range(0, 2)));
    chk("overrun idle", int'(bus.overrun), 0);
    // back-to-back strobe: second one lands in RD_DN and is dropped
    @(negedge CLK);
    bus.x = DW'(500);
    bus.mode = 2'b01;
    bus.win_len = AW'(6);
    bus.audio_ready = 1'b1;
    exp_q.push_back(model(500, 1, 6));
    @(negedge CLK);
    bus.x = DW'(-777);
    @(negedge CLK);
    bus.audio_ready = 1'b0;
    repeat (4) @(negedge CLK);
    chk("overrun set", int'(bus.overrun), 1);
    bus.overrun_clr = 1'b1;
    @(negedge CLK);
    bus.overrun_clr = 1'b0;
    chk("overrun clear", int'(bus.overrun), 0);
    @(negedge CLK);
    bus.x = DW'(321);
    bus.audio_ready = 1'b1;
    exp_q.push_back(model(321, 1, 6));
    @(negedge CLK);
    bus.overrun_clr = 1'b1;
    @(negedge CLK);
    bus.audio_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    chk("overrun set beats clear", int'(bus.overrun), 1);
    repeat (4) @(negedge CLK);
    bus.overrun_clr = 1'b1;
    @(negedge CLK);
    bus.overrun_clr = 1'b0;
    for (int n = 0; n < 8; n++) send(rnd(), int'($urandom_range(0, 3)), 6);
    repeat (10) @(negedge CLK);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/octaver_mix.md
Name: octaver_mix

Overview:
Parametrised successor to the single-mode octaver; sits between the audio codec sample interface and the effects output stage.
- Writes each incoming sample into a circular window buffer.
- Reads the buffer at half rate (octave down), at double rate (octave up), or both, and mixes the result with the dry sample.
- Adds a runtime window length, a uniform fixed latency, output saturation, a valid strobe and overrun detection.

Parameters:
DATA_WIDTH, 32, signed sample width of x and y.
ADDR_WIDTH, 13, buffer address width.
DEPTH, 4000, buffer size in samples and default window length; must be <= 2**ADDR_WIDTH and >= 2.

Ports:
CLK  in  1  system clock.
rst  in  1  reset.
x  in  DATA_WIDTH  signed input sample, sampled when audio_ready is accepted.
audio_ready  in  1  one-cycle strobe, new sample on x.
mode  in  2  00 bypass, 01 octave down, 10 octave up, 11 down+up.
win_len  in  ADDR_WIDTH  window length L; 0 or >DEPTH selects DEPTH.
overrun_clr  in  1  clears overrun.
y  out  DATA_WIDTH  signed mixed output.
y_valid  out  1  one-cycle strobe, y updated.
indicator  out  1  toggles on every window wrap.
overrun  out  1  sticky flag, a sample was dropped.

Behaviour:
- Clock and reset: one clock, CLK; reset rst is asynchronous and active-high.
- Reset values: y=0, y_valid=0, indicator=0, overrun=0, wp=0, primed=0, state IDLE. RAM contents are not reset. Reset asserted mid-operation aborts the sample in flight and produces no y_valid.
- FSM: IDLE -> RD_DN -> RD_UP -> MIX -> OUT -> IDLE.
- Edge 0 (IDLE, audio_ready=1):
  - capture x and latch mode and L;
  - write mem[wp]=x;
  - issue read at addr_dn = wp>>1.
- Edge 1 (RD_DN): register dn data; issue read at addr_up = 2*wp if 2*wp < L, else 2*wp-L.
- Edge 2 (RD_UP): register up data.
- Edge 3 (MIX): form accumulator at DATA_WIDTH+2 bits, all operands sign-extended.
  - wet = 0 if mode=00 or primed=0;
  - wet = dn if mode=01;
  - wet = up if mode=10;
  - wet = (dn+up)>>>1 if mode=11 (arithmetic shift, floor).
  - acc = x + wet.
- Edge 4 (OUT): y = acc saturated to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1]; y_valid=1 for exactly this cycle.
- Latency: y and y_valid update on the 4th rising edge after the edge that accepts audio_ready. This latency applies in every mode, including bypass.
- Pointer update at edge 0:
  - if wp == L-1: wp=0, indicator toggles, primed=1;
  - else wp=wp+1.
- win_len or mode changes take effect only at the next accepted sample. If a new L is <= the current wp, the wrap occurs at the next accepted sample (wp -> 0).
- RAM is read-first: a read of the address written on the same edge returns the old contents.
- Overrun: audio_ready while not in IDLE (states RD_DN..OUT) drops that sample (no write, no pointer change) and sets overrun=1. overrun_clr clears it; set wins over clear in the same cycle. Minimum accepted sample spacing is 5 cycles.

Decomposition:
- Package octaver_pkg: mode constants (MODE_BYP, MODE_DN, MODE_UP, MODE_BOTH), FSM state encoding, and the saturation width constant.
- One sub-module, octaver_ram: 1-write/1-read synchronous RAM, read-first, parameters DATA_WIDTH/ADDR_WIDTH/DEPTH. The FSM time-multiplexes its single read port for the dn and up reads.

Test Plan:
- Reset mid-operation: rst pulsed during RD_UP -> y=0, y_valid stays 0, wp=0, indicator=0; next sample is written at address 0.
- Octave down: win_len=8, mode=01, first window x=1..8 -> y=x (unprimed). Second window x=100+k:
  - k=0 -> y=101 (read-first returns 1);
  - k=4 -> y=104+102=206.
- Octave up: same preload, mode=10, second window k=3 -> addr_up=6 (old value 7) -> y=110; k=5 -> addr_up=2 (new value 102) -> y=207.
- Saturation with DATA_WIDTH=16, mode=01, primed:
  - x=0x7000 with dn=0x7000 -> y=0x7FFF;
  - x=0x9000 with dn=0x9000 -> y=0x8000;
  - mode=11, dn=3, up=-4, x=0 -> y=-1.
- Overrun: audio_ready on two consecutive cycles -> one y_valid, overrun=1, wp advances by 1; overrun_clr -> overrun=0.
- Window wrap: win_len=0 with DEPTH=4000 -> indicator toggles after samples 4000 and 8000. Changing win_len to 5 while wp=10 -> wrap on the next sample.
